// File: rtl/adc_seq_ctrl.sv
// Configuration-and-capture sequencer for a serial-port ADC/codec: programs the
// control registers, enters data mode, then deframes the sample stream per channel.
module adc_seq_ctrl #(
  parameter int                    NUM_REGS      = 8,
  parameter logic [NUM_REGS*8-1:0] INIT_TABLE    = '0,
  parameter logic [15:0]           DATAMODE_WORD = 16'h4101,
  parameter int                    NUM_CH        = 6,
  parameter int                    TIMEOUT_CYC   = 4096
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        SCLK,
  input  logic        SDOFS,
  input  logic        SDO,
  output logic        SDIFS,
  output logic        SDI,
  output logic        SE,
  input  logic        sync,
  input  logic        reinit,
  output logic [15:0] data_o,
  output logic [2:0]  ch_o,
  output logic        valid_o,
  output logic        cfg_done_o,
  output logic        err_o,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_DM, S_WAIT_FS, S_DATA, S_ERROR
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t        state;
  logic [2:0]    sclk_sr;
  logic [1:0]    sdo_sr;
  logic [1:0]    fs_sr;
  logic          rise, fall, sclk_edge, timed, timeout;
  logic [TW-1:0] tcnt;
  logic [3:0]    widx;
  logic [4:0]    bcnt;
  logic [15:0]   cur_word, nxt_word;
  logic [14:0]   rx_sh;
  logic [3:0]    rx_cnt;
  logic          rx_act;
  logic [2:0]    ch_cnt;

  // Word index NUM_REGS selects the data-mode entry word.
  function automatic logic [15:0] word_at(input logic [3:0] i);
    logic [15:0] w;
    w = DATAMODE_WORD;
    for (int k = 0; k < NUM_REGS; k++)
      if (i == k[3:0]) w = {2'b11, 3'b000, k[2:0], INIT_TABLE[8*k +: 8]};
    return w;
  endfunction

  assign rise      = sclk_sr[1] & ~sclk_sr[2];
  assign fall      = ~sclk_sr[1] & sclk_sr[2];
  assign sclk_edge = rise | fall;
  assign timed     = (state == S_CFG) || (state == S_DM) || (state == S_WAIT_FS);
  assign timeout   = timed && !sclk_edge && (tcnt == TW'(TIMEOUT_CYC - 1));
  assign cur_word  = word_at(widx);
  assign nxt_word  = word_at(widx + 4'd1);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sclk_sr <= '0;
      sdo_sr  <= '0;
      fs_sr   <= '0;
    end else begin
      sclk_sr <= {sclk_sr[1:0], SCLK};
      sdo_sr  <= {sdo_sr[0], SDO};
      fs_sr   <= {fs_sr[0], SDOFS};
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= S_IDLE;
      SDI        <= 1'b0;
      SDIFS      <= 1'b0;
      SE         <= 1'b0;
      data_o     <= '0;
      ch_o       <= '0;
      valid_o    <= 1'b0;
      cfg_done_o <= 1'b0;
      err_o      <= 1'b0;
      tcnt       <= '0;
      widx       <= '0;
      bcnt       <= '0;
      rx_sh      <= '0;
      rx_cnt     <= '0;
      rx_act     <= 1'b0;
      ch_cnt     <= '0;
    end else begin
      valid_o <= 1'b0;
      tcnt    <= (sclk_edge || !timed) ? '0 : tcnt + 1'b1;
      if (reinit) begin
        state      <= S_IDLE;
        SE         <= 1'b0;
        SDI        <= 1'b0;
        SDIFS      <= 1'b0;
        err_o      <= 1'b0;
        cfg_done_o <= 1'b0;
        rx_act     <= 1'b0;
      end else if (timeout) begin
        state <= S_ERROR;
        SE    <= 1'b0;
        SDI   <= 1'b0;
        SDIFS <= 1'b0;
        err_o <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            state  <= S_CFG;
            SE     <= 1'b1;
            widx   <= '0;
            bcnt   <= '0;
            rx_act <= 1'b0;
          end
          S_CFG, S_DM: begin
            // bcnt==16 means bit 0 is on the wire; the next rise starts the next word.
            if (rise) begin
              if (bcnt == 5'd16) begin
                if (state == S_DM) begin
                  state <= S_WAIT_FS;
                  SDI   <= 1'b0;
                  SDIFS <= 1'b0;
                end else begin
                  widx  <= widx + 4'd1;
                  SDI   <= nxt_word[15];
                  SDIFS <= 1'b1;
                  bcnt  <= 5'd1;
                  if (widx == 4'(NUM_REGS - 1)) state <= S_DM;
                end
              end else begin
                SDI   <= cur_word[4'd15 - bcnt[3:0]];
                SDIFS <= (bcnt == 5'd0);
                bcnt  <= bcnt + 5'd1;
              end
            end
          end
          S_WAIT_FS, S_DATA: begin
            if (state == S_DATA && sync) ch_cnt <= '0;
            if (fall) begin
              if (fs_sr[1]) begin
                rx_act <= 1'b1;
                rx_cnt <= 4'd1;
                rx_sh  <= {14'b0, sdo_sr[1]};
              end else if (rx_act) begin
                rx_sh  <= {rx_sh[13:0], sdo_sr[1]};
                rx_cnt <= rx_cnt + 4'd1;
                if (rx_cnt == 4'd15) begin
                  rx_act <= 1'b0;
                  if (state == S_WAIT_FS) begin
                    state      <= S_DATA;
                    cfg_done_o <= 1'b1;
                    ch_cnt     <= '0;
                  end else begin
                    data_o  <= {rx_sh, sdo_sr[1]};
                    ch_o    <= ch_cnt;
                    valid_o <= 1'b1;
                    ch_cnt  <= (sync || ch_cnt == 3'(NUM_CH - 1)) ? 3'd0 : ch_cnt + 3'd1;
                  end
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/adc_seq_ctrl.md
# adc_seq_ctrl

Parametrised configuration-and-capture sequencer for a multi-channel serial-port ADC/codec. After reset it programs NUM_REGS control registers from a parameter table, sends the data-mode entry word, then deframes the codec's output stream into per-channel samples tagged with a channel index. It runs entirely in the clk domain, oversampling the codec serial clock, and owns the SDI/SDIFS/SE pins directly.

## Interface
Parameters:
- NUM_REGS, 8: number of control registers written (1..8).
- INIT_TABLE, 64'h0, NUM_REGS×8 bits; byte i is the data for register i (byte 0 in bits [7:0]).
- DATAMODE_WORD, 16'h4101: final control word that switches the codec to data mode.
- NUM_CH, 6: channels per sample frame (1..8).
- TIMEOUT_CYC, 4096: clk cycles without a SCLK edge before an error is flagged.

Ports:
- clk, in, 1: system clock; must be ≥4× SCLK.
- rst_l, in, 1: asynchronous, active-low reset.
- SCLK, in, 1: codec serial clock (asynchronous; 2-flop synchronised).
- SDOFS, in, 1: codec output frame sync (synchronised).
- SDO, in, 1: codec serial data out (synchronised).
- SDIFS, out, 1: input frame sync to the codec.
- SDI, out, 1: serial data to the codec, MSB first.
- SE, out, 1: serial-port enable.
- sync, in, 1: one-clk pulse; the next received frame is channel 0.
- reinit, in, 1: one-clk pulse; restarts the configuration sequence.
- data_o, out, 16: captured sample.
- ch_o, out, 3: channel index of data_o.
- valid_o, out, 1: one-clk pulse when data_o/ch_o are updated.
- cfg_done_o, out, 1: high while in DATA.
- err_o, out, 1: sticky timeout flag.

## Operation
- Control word i = {1'b1, 1'b1, 3'b000, i[2:0], INIT_TABLE[8i+7:8i]}.
- States and transitions:
  - IDLE: goes to CFG one clk after reset release.
  - CFG: sends words 0..NUM_REGS-1 back-to-back, then goes to DM.
  - DM: sends DATAMODE_WORD, then goes to WAIT_FS.
  - WAIT_FS: on the first SDOFS frame start, goes to DATA.
  - DATA: captures frames indefinitely.
  - ERROR: waits for reinit.
- Transmit:
  - On each detected SCLK rising edge, the shifter drives the next bit on SDI.
  - SDIFS is high only during the SCLK period carrying bit 15.
  - One word takes exactly 16 SCLK periods.
  - Consecutive words have no gap: bit 0 of word n is followed directly by bit 15 of word n+1.
  - SDI/SDIFS are 0 outside CFG/DM.
- Receive (WAIT_FS and DATA):
  - A frame starts when SDOFS=1 is seen on a detected SCLK falling edge; SDO at that edge is bit 15.
  - The next 15 falling edges shift in bits 14..0.
  - The frame arriving in WAIT_FS is not output; it only triggers the transition to DATA.
- Channel counter:
  - Reset to 0 on entering DATA.
  - After each frame, the captured sample is output with the current count, then the count increments, wrapping NUM_CH-1 → 0.
  - sync forces the count to 0 for the next frame; if sync coincides with a frame completion, the completed frame keeps its old index.
- reinit:
  - From any state, abort the current word or frame (no valid_o) and go to IDLE.
  - cfg_done_o drops next clk; err_o clears.
- Timeout:
  - In CFG, DM or WAIT_FS, a counter counts clk cycles since the last SCLK edge; it is cleared on every edge.
  - When the count reaches TIMEOUT_CYC, set err_o, go to ERROR, and drive SDI/SDIFS to 0.
  - No timeout applies in DATA.
- SE: 0 in reset, IDLE and ERROR; 1 otherwise.

## Timing
- Reset values: SDI=0, SDIFS=0, SE=0, data_o=0, ch_o=0, valid_o=0, cfg_done_o=0, err_o=0, channel count=0.
- Synchroniser plus edge register: an SCLK edge is detected 3 clk after the pin toggles. SDI/SDIFS update on the clk after detection.
- Frame capture to output: valid_o pulses 1 clk after the falling edge that samples bit 0 is detected; data_o/ch_o update in the same clk and hold until the next valid_o.
- cfg_done_o rises in the clk the WAIT_FS→DATA transition registers.
- An SDOFS frame start mid-frame in DATA: the partial frame is discarded (no valid_o) and a new frame starts.

## Test plan
- Reset: assert rst_l low mid-word -> all outputs 0 immediately. After release, first SDIFS pulse within 2 SCLK periods.
- Config (NUM_REGS=8, INIT_TABLE byte i = 8'h10+i, SCLK=clk/8) -> SDI carries 0xC010, 0xC111 … 0xC717, then 0x4101. That is 144 contiguous bits, with SDIFS exactly on each bit 15.
- Capture (NUM_CH=6): WAIT_FS frame 0xDEAD discarded; frames 0x1111…0x6666, then 0x7777 -> six valid_o pulses with ch_o 0..5, then 0x7777 with ch_o 0.
- sync asserted after 3 data frames -> next frame reported with ch_o=0. Sync coincident with frame completion -> that frame keeps ch_o=2, the following frame gets ch_o=0.
- SCLK stopped in CFG (TIMEOUT_CYC=64) -> err_o=1 at 64 clk after the last edge, SE=0, SDI=0. reinit -> err_o=0 and config restarts from word 0.
- reinit in DATA mid-frame -> no valid_o for the partial frame, cfg_done_o=0 next clk, full 9-word config resent.
